// File: rtl/ser_byte_tx_pkg.sv
// Shared definitions for the byte serializer: FSM encoding, line idle level,
// and the Maxim/Dallas reflected CRC-8 constants plus a one-bit step helper.
// Optional CRC append feature is controlled by macro SER_BYTE_TX_CRC_APPEND_EN.
package ser_byte_tx_pkg;

  // FSM encoding; ST_CRC is only reachable when the CRC append feature is built.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CRC   = 2'd2;

  localparam logic       TXD_IDLE       = 1'b1;
  localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;
  localparam logic [7:0] CRC8_INIT      = 8'h00;

  // One LSB-first step of the reflected CRC-8: feedback enters at bit 7 and
  // also folds into bits 3 and 2 through the reflected polynomial.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic xd;
    xd = bit_in ^ crc[0];
    return (crc >> 1) ^ (xd ? CRC8_POLY_REFL : 8'h00);
  endfunction

endpackage

// File: rtl/ser_byte_tx_crc8_lsb_lfsr.sv
// Bit-serial CRC-8 register (reflected 0x8C), LSB first, with clear and enable.
// Latency: crc_nxt_o is combinational from the held CRC and the current bit.
// No backpressure; only present when SER_BYTE_TX_CRC_APPEND_EN is defined.
`ifdef SER_BYTE_TX_CRC_APPEND_EN
module crc8_lsb_lfsr
  import ser_byte_tx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_nxt_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // Value the register takes if this bit is absorbed; the caller latches it
  // on the final bit of a frame.
  assign crc_nxt_o = crc8_step(crc_q, bit_i);

  // Clear wins over enable so a frame start never mixes in a stale bit.
  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = CRC8_INIT;
    end else if (en_i) begin
      crc_d = crc_nxt_o;
    end
  end

  // CRC state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CRC8_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule
`endif

// File: rtl/ser_byte_tx.sv
// Byte-to-bit serializer, LSB first, BIT_DIV clocks per bit with a BIT_CE strobe.
// Latency: bit 0 drives TXD the cycle after accept; no gap between streamed bytes.
// D_RDY only in IDLE or on a non-final byte's bit-7 strobe. Macro: SER_BYTE_TX_CRC_APPEND_EN.
module ser_byte_tx
  import ser_byte_tx_pkg::*;
#(
  parameter int BIT_DIV = 8,
  parameter int DIV_W   = 8
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic [7:0] D_IN,
  input  logic       D_VLD,
  input  logic       D_LAST,
  output logic       D_RDY,
  output logic       TXD,
  output logic       BIT_CE,
  output logic       BUSY,
  output logic [7:0] CRC_Q
);

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(BIT_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             last_q, last_d;

  logic strobe;
  logic accept;

`ifdef SER_BYTE_TX_CRC_APPEND_EN
  logic [7:0] crc_out_q, crc_out_d;
  logic       crc_clr;
  logic       crc_en;
  logic [7:0] crc_nxt;
`endif

  // Bit-period end: the divider has counted down while a bit is on the line.
  assign strobe = (state_q != ST_IDLE) && (div_q == '0);
  assign BIT_CE = strobe;
  assign BUSY   = (state_q != ST_IDLE);
  assign TXD    = (state_q == ST_IDLE) ? TXD_IDLE : shift_q[0];

  // Streaming window: a follow-on byte can only join on the last strobe of a
  // non-final byte, so TXD never shows an idle bit inside a frame.
  assign D_RDY  = (state_q == ST_IDLE) ||
                  ((state_q == ST_SHIFT) && strobe && (bit_cnt_q == 3'd7) && !last_q);
  assign accept = D_VLD && D_RDY;

  // Next-state logic for the FSM, shifter, bit counter and divider.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    last_d    = last_q;
`ifdef SER_BYTE_TX_CRC_APPEND_EN
    crc_out_d = crc_out_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          shift_d   = D_IN;
          bit_cnt_d = 3'd0;
          div_d     = DIV_RELOAD;
          last_d    = D_LAST;
`ifdef SER_BYTE_TX_CRC_APPEND_EN
          crc_clr   = 1'b1;
`endif
        end
      end
      ST_SHIFT: begin
        if (!strobe) begin
          div_d = div_q - 1'b1;
        end else begin
`ifdef SER_BYTE_TX_CRC_APPEND_EN
          crc_en = 1'b1;
`endif
          if (bit_cnt_q != 3'd7) begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            div_d     = DIV_RELOAD;
          end else if (accept) begin
            // Streamed byte: the working CRC keeps accumulating.
            shift_d   = D_IN;
            bit_cnt_d = 3'd0;
            div_d     = DIV_RELOAD;
            last_d    = D_LAST;
          end else if (last_q) begin
`ifdef SER_BYTE_TX_CRC_APPEND_EN
            crc_out_d = crc_nxt;
            state_d   = ST_CRC;
            shift_d   = crc_nxt;
            bit_cnt_d = 3'd0;
            div_d     = DIV_RELOAD;
`else
            state_d   = ST_IDLE;
`endif
          end else begin
            // Underrun: drop back to idle; working CRC is kept until next accept.
            state_d = ST_IDLE;
          end
        end
      end
`ifdef SER_BYTE_TX_CRC_APPEND_EN
      ST_CRC: begin
        if (!strobe) begin
          div_d = div_q - 1'b1;
        end else if (bit_cnt_q != 3'd7) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          div_d     = DIV_RELOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and FSM registers.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      div_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      last_q    <= last_d;
    end
  end

`ifdef SER_BYTE_TX_CRC_APPEND_EN
  crc8_lsb_lfsr u_crc (
    .clk_i     (CLK),
    .rst_ni    (CLR_N),
    .clr_i     (crc_clr),
    .en_i      (crc_en),
    .bit_i     (TXD),
    .crc_nxt_o (crc_nxt)
  );

  // Frame CRC, updated only when a LAST byte completes.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      crc_out_q <= CRC8_INIT;
    end else begin
      crc_out_q <= crc_out_d;
    end
  end

  assign CRC_Q = crc_out_q;
`else
  assign CRC_Q = CRC8_INIT;
`endif

endmodule

// File: tb/tb_ser_byte_tx.sv
// Self-checking bench for ser_byte_tx: scoreboard of expected TXD bits per strobe.
// Two instances: BIT_DIV=4 for frame scenarios and BIT_DIV=1 for the boundary case.
// Honours SER_BYTE_TX_CRC_APPEND_EN to expect appended CRC bits.
module tb_ser_byte_tx;

  logic       clk;
  logic       clr_n;
  logic [7:0] d_in;
  logic       d_vld, d_last;
  logic       d_rdy, txd, bit_ce, busy;
  logic [7:0] crc_q;
  logic [7:0] d1_in;
  logic       d1_vld, d1_last;
  logic       d1_rdy, txd1, bit_ce1, busy1;
  logic [7:0] crc1_q;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] stim_d[$];
  logic       stim_l[$];
  logic       exp_q[$];
  logic       obs_q[$];
  logic [7:0] mcrc;

  int busy_cnt, ce_cnt, gap_err, hold_err, busy_runs;
  bit acc_on_ce, timed_out;

  ser_byte_tx #(.BIT_DIV(4), .DIV_W(8)) u_dut (
    .CLK(clk), .CLR_N(clr_n), .D_IN(d_in), .D_VLD(d_vld), .D_LAST(d_last),
    .D_RDY(d_rdy), .TXD(txd), .BIT_CE(bit_ce), .BUSY(busy), .CRC_Q(crc_q)
  );

  ser_byte_tx #(.BIT_DIV(1), .DIV_W(8)) u_dut1 (
    .CLK(clk), .CLR_N(clr_n), .D_IN(d1_in), .D_VLD(d1_vld), .D_LAST(d1_last),
    .D_RDY(d1_rdy), .TXD(txd1), .BIT_CE(bit_ce1), .BUSY(busy1), .CRC_Q(crc1_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference CRC-8 step written out bit by bit from the polynomial taps.
  function automatic logic [7:0] model_crc_bit(input logic [7:0] c, input logic b);
    logic xd;
    xd = b ^ c[0];
    return {xd, c[7], c[6], c[5], c[4] ^ xd, c[3] ^ xd, c[2], c[1]};
  endfunction

  // Queue one byte as stimulus and its expected line bits; close frame if last.
  task automatic push_byte(input logic [7:0] b, input logic last);
    stim_d.push_back(b);
    stim_l.push_back(last);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      mcrc = model_crc_bit(mcrc, b[i]);
    end
`ifdef SER_BYTE_TX_CRC_APPEND_EN
    if (last) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(mcrc[i]);
    end
`endif
  endtask

  // Drive the queued bytes into u_dut and record what appears on the line.
  task automatic run4(input int max_cyc);
    bit acc, prev_busy, prev_ce, started;
    logic prev_txd;
    int last_ce;
    obs_q.delete();
    busy_cnt = 0; ce_cnt = 0; gap_err = 0; hold_err = 0; busy_runs = 0;
    acc_on_ce = 0; timed_out = 1;
    prev_busy = 0; prev_ce = 0; prev_txd = 1'b1; started = 0; last_ce = -1;
    @(negedge clk);
    d_in = stim_d[0]; d_last = stim_l[0]; d_vld = 1'b1;
    acc = d_vld && d_rdy;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (!prev_busy) busy_runs++;
        started = 1;
      end
      if (busy && prev_busy && !prev_ce && (txd !== prev_txd)) hold_err++;
      if (bit_ce) begin
        ce_cnt++;
        obs_q.push_back(txd);
        if (last_ce >= 0 && (cyc - last_ce) != 4) gap_err++;
        last_ce = cyc;
      end
      prev_busy = busy; prev_ce = bit_ce; prev_txd = txd;
      if (acc) begin
        void'(stim_d.pop_front());
        void'(stim_l.pop_front());
        if (stim_d.size() > 0) begin
          d_in = stim_d[0]; d_last = stim_l[0];
        end else begin
          d_vld = 1'b0; d_in = 8'h00; d_last = 1'b0;
        end
      end
      acc = d_vld && d_rdy;
      if (acc && started) acc_on_ce = bit_ce;
      if (started && !busy && !d_vld) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    d_in = 8'h00; d_vld = 1'b0; d_last = 1'b0;
    d1_in = 8'h00; d1_vld = 1'b0; d1_last = 1'b0;
    #3;
    n_chk++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd); else n_pass++;
    n_chk++; if (d_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", d_rdy); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (bit_ce !== 1'b0) $display("FAIL reset_ce: got %b want 0", bit_ce); else n_pass++;
    n_chk++; if (crc_q !== 8'h00) $display("FAIL reset_crc: got %h want 00", crc_q); else n_pass++;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic e, o;
    int exp_busy;
    mcrc = 8'h00;
    push_byte(8'hA5, 1'b1);
    exp_busy = exp_q.size() * 4;
    run4(200);
    n_chk++; if (timed_out) $display("FAIL single_timeout: frame never completed"); else n_pass++;
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL single_nbits: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_chk++; if (o !== e) $display("FAIL single_bit%0d: got %b want %b", i, o, e); else n_pass++;
    end
    n_chk++; if (busy_cnt != exp_busy) $display("FAIL single_busy: got %0d want %0d", busy_cnt, exp_busy); else n_pass++;
    n_chk++; if (gap_err != 0) $display("FAIL single_ce_spacing: got %0d bad gaps want 0", gap_err); else n_pass++;
    n_chk++; if (hold_err != 0) $display("FAIL single_hold: got %0d mid-bit changes want 0", hold_err); else n_pass++;
    n_chk++; if (txd !== 1'b1 || d_rdy !== 1'b1) $display("FAIL single_idle: got txd=%b rdy=%b want 1 1", txd, d_rdy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic e, o;
    int exp_busy;
    mcrc = 8'h00;
    push_byte(8'h01, 1'b0);
    push_byte(8'h02, 1'b1);
    exp_busy = exp_q.size() * 4;
    run4(400);
    n_chk++; if (timed_out) $display("FAIL b2b_timeout: frame never completed"); else n_pass++;
    n_chk++; if (acc_on_ce !== 1'b1) $display("FAIL b2b_accept_on_strobe: got %b want 1", acc_on_ce); else n_pass++;
    n_chk++; if (busy_runs != 1) $display("FAIL b2b_no_gap: got %0d busy runs want 1", busy_runs); else n_pass++;
    n_chk++; if (busy_cnt != exp_busy) $display("FAIL b2b_busy: got %0d want %0d", busy_cnt, exp_busy); else n_pass++;
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_nbits: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_chk++; if (o !== e) $display("FAIL b2b_bit%0d: got %b want %b", i, o, e); else n_pass++;
    end
`ifdef SER_BYTE_TX_CRC_APPEND_EN
    n_chk++; if (crc_q !== mcrc) $display("FAIL b2b_crc: got %h want %h", crc_q, mcrc); else n_pass++;
`endif
  endtask

  task automatic test_crc_append;
`ifdef SER_BYTE_TX_CRC_APPEND_EN
    logic e, o;
    logic [7:0] crc_bits;
    mcrc = 8'h00;
    push_byte(8'h01, 1'b1);
    n_chk++; if (mcrc !== 8'h5E) $display("FAIL crc_model: got %h want 5e", mcrc); else n_pass++;
    run4(400);
    n_chk++; if (timed_out) $display("FAIL crc_timeout: frame never completed"); else n_pass++;
    n_chk++; if (crc_q !== 8'h5E) $display("FAIL crc_value: got %h want 5e", crc_q); else n_pass++;
    n_chk++; if (busy_cnt != 64) $display("FAIL crc_busy: got %0d want 64", busy_cnt); else n_pass++;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_chk++; if (o !== e) $display("FAIL crc_bit%0d: got %b want %b", i, o, e); else n_pass++;
    end
    crc_bits = 8'h5E;
    mcrc = 8'h00;
    for (int i = 0; i < 8; i++) mcrc = model_crc_bit(mcrc, (i == 0));
    for (int i = 0; i < 8; i++) mcrc = model_crc_bit(mcrc, crc_bits[i]);
    n_chk++; if (mcrc !== 8'h00) $display("FAIL crc_residue: got %h want 00", mcrc); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid;
    logic e, o;
    @(negedge clk);
    d_in = 8'h00; d_last = 1'b1; d_vld = 1'b1;
    @(negedge clk);
    d_vld = 1'b0; d_last = 1'b0;
    repeat (9) @(negedge clk);
    n_chk++; if (busy !== 1'b1 || txd !== 1'b0) $display("FAIL midrst_pre: got busy=%b txd=%b want 1 0", busy, txd); else n_pass++;
    #2 clr_n = 1'b0;
    #1;
    n_chk++; if (txd !== 1'b1) $display("FAIL midrst_txd: got %b want 1", txd); else n_pass++;
    n_chk++; if (d_rdy !== 1'b1) $display("FAIL midrst_rdy: got %b want 1", d_rdy); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (bit_ce !== 1'b0) $display("FAIL midrst_ce: got %b want 0", bit_ce); else n_pass++;
    n_chk++; if (crc_q !== 8'h00) $display("FAIL midrst_crc: got %h want 00", crc_q); else n_pass++;
    @(negedge clk);
    clr_n = 1'b1;
    mcrc = 8'h00;
    push_byte(8'h01, 1'b1);
    run4(400);
    n_chk++; if (timed_out) $display("FAIL restart_timeout: frame never completed"); else n_pass++;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_chk++; if (o !== e) $display("FAIL restart_bit%0d: got %b want %b", i, o, e); else n_pass++;
    end
`ifdef SER_BYTE_TX_CRC_APPEND_EN
    n_chk++; if (crc_q !== 8'h5E) $display("FAIL restart_crc: got %h want 5e", crc_q); else n_pass++;
`else
    n_chk++; if (crc_q !== 8'h00) $display("FAIL restart_crc: got %h want 00", crc_q); else n_pass++;
`endif
  endtask

  task automatic test_bitdiv1;
    int b_cnt, c_cnt, ce_miss, ones_err, runs, exp_cnt;
    bit started, prev_b, done;
    b_cnt = 0; c_cnt = 0; ce_miss = 0; ones_err = 0; runs = 0;
    started = 0; prev_b = 0; done = 0;
`ifdef SER_BYTE_TX_CRC_APPEND_EN
    exp_cnt = 16;
`else
    exp_cnt = 8;
`endif
    @(negedge clk);
    d1_in = 8'hFF; d1_last = 1'b1; d1_vld = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      d1_vld = 1'b0; d1_last = 1'b0; d1_in = 8'h00;
      if (busy1) begin
        b_cnt++;
        if (!prev_b) runs++;
        started = 1;
        if (!bit_ce1) ce_miss++;
        if (b_cnt <= 8 && txd1 !== 1'b1) ones_err++;
      end
      if (bit_ce1) c_cnt++;
      prev_b = busy1;
      if (started && !busy1) begin
        done = 1;
        break;
      end
    end
    n_chk++; if (!done) $display("FAIL div1_timeout: frame never completed"); else n_pass++;
    n_chk++; if (b_cnt != exp_cnt) $display("FAIL div1_busy: got %0d want %0d", b_cnt, exp_cnt); else n_pass++;
    n_chk++; if (c_cnt != exp_cnt) $display("FAIL div1_ce_count: got %0d want %0d", c_cnt, exp_cnt); else n_pass++;
    n_chk++; if (ce_miss != 0) $display("FAIL div1_ce_every_cycle: got %0d misses want 0", ce_miss); else n_pass++;
    n_chk++; if (ones_err != 0) $display("FAIL div1_txd_ones: got %0d zero bits want 0", ones_err); else n_pass++;
    n_chk++; if (runs != 1) $display("FAIL div1_contiguous: got %0d busy runs want 1", runs); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_crc_append();
    test_reset_mid();
    test_bitdiv1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
